// File: rtl/round_final_dec.sv
// round_final_dec: last AES decryption stage, OUT = InvSubBytes(InvShiftRows(IN)) ^ K0, as a 2-stage valid/ready pipeline.
// Optional feature macro DEC_FINAL_CNT_EN adds a 16-bit completed-block counter on blk_cnt; otherwise blk_cnt is tied to zero.
module round_final_dec #(
    parameter int BLOCK_LENGTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BLOCK_LENGTH-1:0] IN,
    input  logic [BLOCK_LENGTH-1:0] KEY,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BLOCK_LENGTH-1:0] OUT,
    output logic [15:0]             blk_cnt
);

    // Inverse S-box, entry 0 in the top byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [10:0] base;
        base = 11'd2047 - {b, 3'b000};
        return INV_SBOX[base -: 8];
    endfunction

    logic [BLOCK_LENGTH-1:0] inv_state_s;
    logic                    s2_free_s;
    logic                    s1_adv_s;
    logic                    in_xfer_s;
    logic                    s1_valid_r;
    logic [BLOCK_LENGTH-1:0] s1_state_r;
    logic [BLOCK_LENGTH-1:0] s1_key_r;
    logic                    out_valid_r;
    logic [BLOCK_LENGTH-1:0] out_r;

    // Byte s[r,c] (index r+4c) is taken from column (c-r) mod 4, then inverse-substituted.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            localparam int DST = r + 4 * c;
            localparam int SRC = r + 4 * ((c + 4 - r) % 4);
            assign inv_state_s[BLOCK_LENGTH-1-8*DST -: 8] = inv_sbox(IN[BLOCK_LENGTH-1-8*SRC -: 8]);
        end
    end

    assign s2_free_s = !out_valid_r || out_ready;
    assign s1_adv_s  = s1_valid_r && s2_free_s;
    assign in_ready  = enable && rst && (!s1_valid_r || s2_free_s);
    assign in_xfer_s = in_valid && in_ready;

    // Stage 1: capture the transformed state together with its own key.
    always_ff @(posedge clk) begin
        if (!rst || !enable) begin
            s1_valid_r <= 1'b0;
            s1_state_r <= {BLOCK_LENGTH{1'b0}};
            s1_key_r   <= {BLOCK_LENGTH{1'b0}};
        end else if (in_xfer_s) begin
            s1_valid_r <= 1'b1;
            s1_state_r <= inv_state_s;
            s1_key_r   <= KEY;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: key add into the output register; OUT holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst || !enable) begin
            out_valid_r <= 1'b0;
            out_r       <= {BLOCK_LENGTH{1'b0}};
        end else if (s1_adv_s) begin
            out_valid_r <= 1'b1;
            out_r       <= s1_state_r ^ s1_key_r;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign OUT       = out_r;

`ifdef DEC_FINAL_CNT_EN
    logic [15:0] blk_cnt_r;

    // Completed-block counter; only reset clears it, enable does not.
    always_ff @(posedge clk) begin
        if (!rst) begin
            blk_cnt_r <= 16'h0000;
        end else if (out_valid_r && out_ready) begin
            blk_cnt_r <= blk_cnt_r + 16'h0001;
        end else begin
            blk_cnt_r <= blk_cnt_r;
        end
    end

    assign blk_cnt = blk_cnt_r;
`else
    assign blk_cnt = 16'h0000;
`endif

endmodule
